// File: rtl/reg_seq_ctrl_pkg.sv
// Shared types for the pipeline-register load sequencer.
// State encoding and default stage count.
package reg_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int DEF_N_STAGES = 4;

endpackage

// File: rtl/reg_seq_ctrl_if.sv
// Control/status bundle between a requester and the sequencer.
// master drives requests; slave is the sequencer.
interface reg_seq_ctrl_if #(
    parameter int N_STAGES = 4,
    parameter int WAIT_W   = 4,
    parameter int IDX_W    = 2
);
    logic                start;
    logic [WAIT_W-1:0]   wait_cfg;
    logic                abort;
    logic                clr_ovr;
    logic [N_STAGES-1:0] en;
    logic [IDX_W-1:0]    stage;
    logic                busy;
    logic                done;
    logic                overrun;

    modport master (
        output start, wait_cfg, abort, clr_ovr,
        input  en, stage, busy, done, overrun
    );

    modport slave (
        input  start, wait_cfg, abort, clr_ovr,
        output en, stage, busy, done, overrun
    );
endinterface

// File: rtl/reg_seq_ctrl_wait_cnt.sv
// Loadable down-counter; last is registered and high while the count is 1.
// Decrement stops at zero so the counter never wraps.
module seq_wait_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] val,
    input  logic         dec,
    output logic         last
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            last <= 1'b0;
        end else if (load) begin
            cnt  <= val;
            last <= (val == W'(1));
        end else if (dec && cnt != '0) begin
            cnt  <= cnt - W'(1);
            last <= (cnt == W'(2));
        end
    end
endmodule

// File: rtl/reg_seq_ctrl.sv
// Sequencer issuing one-hot load enables to a chain of pipeline registers,
// with programmable settle cycles between loads and a sticky overrun flag.
module reg_seq_ctrl
    import reg_seq_ctrl_pkg::*;
#(
    parameter int N_STAGES = DEF_N_STAGES,
    parameter int WAIT_W   = 4,
    parameter int IDX_W    = 2
) (
    input  logic          clk,
    input  logic          rst,
    reg_seq_ctrl_if.slave bus
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_STAGES - 1);

    state_t              state, state_n;
    logic [IDX_W-1:0]    stage_q, stage_n;
    logic [WAIT_W-1:0]   wcfg_q;
    logic                wcfg_ld, cnt_ld, cnt_dec, cnt_last, ovr_set;
    logic [N_STAGES-1:0] en_q;
    logic                busy_q, done_q, ovr_q;

    seq_wait_cnt #(.W(WAIT_W)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_ld),
        .val  (wcfg_q),
        .dec  (cnt_dec),
        .last (cnt_last)
    );

    always_comb begin
        state_n = state;
        stage_n = stage_q;
        wcfg_ld = 1'b0;
        cnt_ld  = 1'b0;
        cnt_dec = 1'b0;
        ovr_set = bus.start && (state == ST_LOAD || state == ST_WAIT);
        unique case (state)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_n = ST_LOAD;
                    stage_n = '0;
                    wcfg_ld = 1'b1;
                end
            end
            ST_LOAD: begin
                if (bus.abort) begin
                    state_n = ST_IDLE;
                    stage_n = '0;
                end else if (wcfg_q != '0) begin
                    state_n = ST_WAIT;
                    cnt_ld  = 1'b1;
                end else if (stage_q == LAST_IDX) begin
                    state_n = ST_DONE;
                end else begin
                    stage_n = stage_q + IDX_W'(1);
                end
            end
            ST_WAIT: begin
                if (bus.abort) begin
                    state_n = ST_IDLE;
                    stage_n = '0;
                end else if (!cnt_last) begin
                    cnt_dec = 1'b1;
                end else if (stage_q == LAST_IDX) begin
                    state_n = ST_DONE;
                end else begin
                    state_n = ST_LOAD;
                    stage_n = stage_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                // abort in the done cycle drops a back-to-back start
                if (bus.start && !bus.abort) begin
                    state_n = ST_LOAD;
                    stage_n = '0;
                    wcfg_ld = 1'b1;
                end else begin
                    state_n = ST_IDLE;
                    stage_n = '0;
                end
            end
            default: begin
                state_n = ST_IDLE;
                stage_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            stage_q <= '0;
            wcfg_q  <= '0;
            en_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state   <= state_n;
            stage_q <= stage_n;
            if (wcfg_ld) wcfg_q <= bus.wait_cfg;
            en_q    <= (state_n == ST_LOAD) ? (N_STAGES'(1) << stage_n) : '0;
            busy_q  <= (state_n != ST_IDLE);
            done_q  <= (state_n == ST_DONE);
            ovr_q   <= ovr_set | (ovr_q & ~bus.clr_ovr);
        end
    end

    assign bus.en      = en_q;
    assign bus.stage   = stage_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.overrun = ovr_q;
endmodule

// File: doc/reg_seq_ctrl.md
Name: reg_seq_ctrl

Overview:
- Sequencer for a chain of enable-gated pipeline registers (19-bit datapath stages) in the fixed-point processing path.
- On each accepted start strobe (sample ready), it issues one-cycle load enables to stages 0..N_STAGES-1 in order.
- Between loads it inserts a runtime-programmable number of wait cycles so combinational arithmetic between stages can settle.
- It flags completion with a done pulse and records overruns in a sticky flag.

Parameters:
- N_STAGES, 4, number of register stages sequenced (2..16).
- WAIT_W, 4, width of the wait-cycle configuration input.
- IDX_W, 2, width of the stage index output; must equal clog2(N_STAGES).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous assert, active-low (0 = reset).
- start  in  1  one-cycle request to run one full sequence.
- wait_cfg  in  WAIT_W  wait cycles after each stage load; latched when start is accepted.
- abort  in  1  synchronous cancel of the running sequence.
- clr_ovr  in  1  synchronous clear of the overrun flag.
- en  out  N_STAGES  one-hot load enables, wired to the EN input of each stage register.
- stage  out  IDX_W  index of the stage currently loading or waiting.
- busy  out  1  high from the first load cycle through the done cycle.
- done  out  1  one-cycle pulse after the last stage's wait completes.
- overrun  out  1  sticky; set when start arrives while the block cannot accept it.

Behaviour:
- All outputs are registered.
- Reset (rst=0): asynchronously forces state=IDLE, en=0, stage=0, busy=0, done=0, overrun=0, and clears the wait counter and the latched wait value.
- Reset applied mid-sequence aborts the sequence immediately; no done pulse is produced.
- States and transitions:
  - IDLE: start=1 at a clock edge moves to LOAD with stage=0 and latches wcfg=wait_cfg.
  - LOAD: en[stage]=1 for exactly one cycle. If wcfg=0, go to LOAD of stage+1, or to DONE if this is the last stage. Otherwise go to WAIT with cnt=wcfg.
  - WAIT: cnt decrements each cycle. Leave WAIT on the cycle cnt reaches 1: go to LOAD of stage+1, or to DONE if this is the last stage. WAIT therefore lasts exactly wcfg cycles.
  - DONE: done=1 for one cycle. start=1 in this cycle is accepted back-to-back: go to LOAD with stage=0 and latch the new wait_cfg. Otherwise go to IDLE.
- Latency: with start sampled at edge 0, en[0] is high in cycle 1. Done is high in cycle N_STAGES*(1+wcfg)+1.
- busy=1 in LOAD, WAIT and DONE; busy=0 only in IDLE.
- en is one-hot or zero in every cycle; it is zero in IDLE, WAIT and DONE.
- stage holds its value through WAIT and returns to 0 in IDLE.
- start while in LOAD or WAIT: ignored, overrun set at the next edge.
- overrun stays set until clr_ovr=1. If a new overrun and clr_ovr occur in the same cycle, set has priority.
- abort=1 in LOAD or WAIT: next state is IDLE, en=0, no done pulse.
- abort=1 in DONE: the done pulse still completes, and any start in that same cycle is dropped.
- abort and start together in IDLE: abort has priority and start is dropped. No overrun is flagged for a dropped start.
- Changes to wait_cfg during a sequence have no effect; only the value latched at start is used.
- Arithmetic: the wait counter is WAIT_W bits and only decrements, so it never wraps.

Decomposition:
- Shared package: state encoding (IDLE, LOAD, WAIT, DONE as a 2-bit localparam set) and the default stage count.
- Sub-module seq_wait_cnt: a loadable down-counter with a load value, a decrement enable and a registered "last" flag (cnt==1). It uses the same clock and reset.
- The FSM and the one-hot decoder stay in the top module.

Test Plan:
- Basic run: N=4, wait_cfg=2, start pulse at cycle 0. Expect en=0001 in cycle 1, 0010 in cycle 4, 0100 in cycle 7, 1000 in cycle 10; done in cycle 13; busy high in cycles 1..13.
- Zero wait: wait_cfg=0. Expect en to walk 0001, 0010, 0100, 1000 in cycles 1..4, done in cycle 5, then IDLE.
- Back-to-back and overrun:
  - start held in the done cycle: expect en=0001 in the next cycle with no idle gap.
  - start in cycle 5 of a running sequence: expect overrun=1 from cycle 6, sequence unaffected, overrun cleared by clr_ovr.
- Abort: abort in cycle 5 of a wait_cfg=2 run. Expect en=0, busy=0 from cycle 6 and no done pulse; a new start is then accepted normally.
- Async reset: drive rst=0 mid-WAIT between clock edges. Expect all outputs 0 immediately without waiting for a clock edge. After rst=1, the block stays idle until the next start.
- Config latch: change wait_cfg from 2 to 7 during a run. Expect the spacing between loads to stay at 3 cycles.
